// File: rtl/dot_matrix_scan.sv
// dot_matrix_scan: column-scan driver for a ROWS x COLS LED dot-matrix panel.
// Holds GLYPHS frames in a writable glyph RAM. Scans one column every DIV
// clocks, blanks the rows for BLANK clocks at each column change to suppress
// ghosting, and only switches glyphs on frame boundaries.
// Optional feature macro: DOT_MATRIX_SCAN_SCROLL_EN adds a scroll_en input and
// a per-frame column offset so the selected glyph scrolls horizontally.
module dot_matrix_scan #(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int GLYPHS = 4,
    parameter int DIV    = 1000,
    parameter int BLANK  = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$clog2(GLYPHS)-1:0]   glyph_sel,
    input  logic                        glyph_req,
    input  logic                        wr_en,
    input  logic [$clog2(GLYPHS)-1:0]   wr_glyph,
    input  logic [$clog2(COLS)-1:0]     wr_col,
    input  logic [ROWS-1:0]             wr_data,
`ifdef DOT_MATRIX_SCAN_SCROLL_EN
    input  logic                        scroll_en,
`endif
    output logic [ROWS-1:0]             Dot_R,
    output logic [$clog2(COLS)-1:0]     Dot_C,
    output logic                        frame_start,
    output logic [$clog2(GLYPHS)-1:0]   cur_glyph
);

    localparam int CW = $clog2(COLS);
    localparam int GW = $clog2(GLYPHS);
    localparam int PW = $clog2(DIV);
    localparam int AW = GW + CW;

    logic [PW-1:0]   pre;
    logic [PW-1:0]   pre_nxt;
    logic [CW-1:0]   col_nxt;
    logic [CW-1:0]   off_nxt;
    logic [GW-1:0]   glyph_nxt;
    logic [GW-1:0]   pend;
    logic            pend_vld;
    logic            col_adv;
    logic            wrap;
    logic [AW-1:0]   rd_addr;

    // Patterns are stored inverted so that a RAM that powers up cleared
    // presents all-ones (LEDs off) until a glyph is written.
    logic [ROWS-1:0] mem_n [0:GLYPHS*COLS-1];

`ifdef DOT_MATRIX_SCAN_SCROLL_EN
    logic [CW-1:0]   off;
`endif

    // Next-state values; the row load uses them so that with BLANK=0 it sees
    // the column and glyph that become current on the same edge.
    always_comb begin
        col_adv   = (pre == PW'(DIV - 1));
        wrap      = col_adv && (Dot_C == CW'(COLS - 1));
        pre_nxt   = col_adv ? '0 : pre + 1'b1;
        col_nxt   = col_adv ? Dot_C + 1'b1 : Dot_C;
        glyph_nxt = (wrap && pend_vld) ? pend : cur_glyph;
`ifdef DOT_MATRIX_SCAN_SCROLL_EN
        off_nxt   = off;
        if (wrap) begin
            // A glyph switch restarts the new glyph unscrolled.
            if (pend_vld)
                off_nxt = '0;
            else if (scroll_en)
                off_nxt = off + 1'b1;
        end
`else
        off_nxt   = '0;
`endif
        rd_addr   = {glyph_nxt, CW'(col_nxt + off_nxt)};
    end

    // Scan timing, glyph switching and the pending-request slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre         <= '0;
            Dot_C       <= '0;
            cur_glyph   <= '0;
            pend        <= '0;
            pend_vld    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pre         <= pre_nxt;
            Dot_C       <= col_nxt;
            cur_glyph   <= glyph_nxt;
            frame_start <= wrap;
            // A request on the wrap edge survives into the next frame.
            if (glyph_req) begin
                pend     <= glyph_sel;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
        end
    end

`ifdef DOT_MATRIX_SCAN_SCROLL_EN
    // Horizontal scroll offset, advanced once per frame.
    always_ff @(posedge clock) begin
        if (reset)
            off <= '0;
        else
            off <= off_nxt;
    end
`endif

    // Row drive: blank early in each column, then load and hold the pattern.
    always_ff @(posedge clock) begin
        if (reset)
            Dot_R <= '1;
        else if (int'(pre_nxt) < BLANK)
            Dot_R <= '1;
        else if (int'(pre_nxt) == BLANK)
            Dot_R <= ~mem_n[rd_addr];
    end

    // Glyph RAM write port; the row load above reads the pre-write contents.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem_n[{wr_glyph, wr_col}] <= ~wr_data;
    end

endmodule
